// File: rtl/regfile_wb_ctrl.sv
// Register-file write-port owner: merges load returns (priority) with buffered ALU results and tracks pending destinations.
// Optional stall counter output enabled by defining REGFILE_WB_STALL_CNT_EN.
module regfile_wb_ctrl #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [4:0]       alu_dest,
  input  logic [31:0]      alu_data,
  input  logic             ld_valid,
  input  logic [4:0]       ld_dest,
  input  logic [31:0]      ld_data,
  input  logic             iss_valid,
  input  logic [4:0]       iss_dest,
  output logic [31:0]      pending,
  output logic             wren,
  output logic [4:0]       wr,
  output logic [31:0]      wd,
  output logic [CNT_W-1:0] fifo_count
`ifdef REGFILE_WB_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  localparam int unsigned PTR_W = CNT_W - 1;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_LOAD,
    SRC_FIFO,
    SRC_BYPASS
  } src_t;

  logic [4:0]       mem_dest [FIFO_DEPTH];
  logic [31:0]      mem_data [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  src_t        src;
  logic        empty;
  logic        full;
  logic        alu_use;
  logic        ld_use;
  logic        push;
  logic        pop;
  logic [4:0]  sel_dest;
  logic [31:0] sel_data;
  logic [31:0] pending_nxt;

  assign empty     = (fifo_count == '0);
  assign full      = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign alu_ready = !full;
  assign alu_use   = alu_valid && alu_ready && (alu_dest != 5'd0);
  assign ld_use    = ld_valid && (ld_dest != 5'd0);

  always_comb begin
    src      = SRC_NONE;
    sel_dest = '0;
    sel_data = '0;
    pop      = 1'b0;
    if (ld_use) begin
      src      = SRC_LOAD;
      sel_dest = ld_dest;
      sel_data = ld_data;
    end else if (!empty) begin
      src      = SRC_FIFO;
      sel_dest = mem_dest[rd_ptr];
      sel_data = mem_data[rd_ptr];
      pop      = 1'b1;
    end else if (alu_use) begin
      src      = SRC_BYPASS;
      sel_dest = alu_dest;
      sel_data = alu_data;
    end
    push = alu_use && (src != SRC_BYPASS);
  end

  // Clear for the write being registered first, so a same-cycle issue re-sets the bit.
  always_comb begin
    pending_nxt = pending;
    if (src != SRC_NONE)
      pending_nxt[sel_dest] = 1'b0;
    if (iss_valid && (iss_dest != 5'd0))
      pending_nxt[iss_dest] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_dest[wr_ptr] <= alu_dest;
      mem_data[wr_ptr] <= alu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      wren       <= 1'b0;
      wr         <= '0;
      wd         <= '0;
      pending    <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      wren <= (src != SRC_NONE);
      if (src != SRC_NONE) begin
        wr <= sel_dest;
        wd <= sel_data;
      end
      pending <= pending_nxt;
    end
  end

`ifdef REGFILE_WB_STALL_CNT_EN
  logic stall_hit;

  assign stall_hit = (alu_valid && !alu_ready) || (ld_use && !empty);

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (stall_hit && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed self-checking bench for regfile_wb_ctrl.
module tb_regfile_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_dest;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic [4:0]  ld_dest;
  logic [31:0] ld_data;
  logic        iss_valid;
  logic [4:0]  iss_dest;
  logic [31:0] pending;
  logic        wren;
  logic [4:0]  wr;
  logic [31:0] wd;
  logic [2:0]  fifo_count;
`ifdef REGFILE_WB_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;

  regfile_wb_ctrl #(.FIFO_DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_dest(ld_dest), .ld_data(ld_data),
    .iss_valid(iss_valid), .iss_dest(iss_dest),
    .pending(pending), .wren(wren), .wr(wr), .wd(wd), .fifo_count(fifo_count)
`ifdef REGFILE_WB_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_dest = '0; alu_data = '0;
    ld_valid  = 1'b0; ld_dest  = '0; ld_data  = '0;
    iss_valid = 1'b0; iss_dest = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic chk_write(input string name, input logic exp_en, input logic [4:0] exp_wr,
                           input logic [31:0] exp_wd);
    tests_run++;
    if (wren !== exp_en || (exp_en && (wr !== exp_wr || wd !== exp_wd))) begin
      tests_failed++;
      $display("FAIL %s: got wren=%b wr=%0d wd=%h, expected wren=%b wr=%0d wd=%h",
               name, wren, wr, wd, exp_en, exp_wr, exp_wd);
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (wren !== 1'b0 || wr !== 5'd0 || wd !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_write: got wren=%b wr=%0d wd=%h, expected 0/0/0", wren, wr, wd);
    end
    tests_run++;
    if (pending !== 32'd0 || fifo_count !== 3'd0 || alu_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_state: got pending=%h count=%0d ready=%b, expected 0/0/1",
               pending, fifo_count, alu_ready);
    end
  endtask

  task automatic test_bypass();
    alu_valid = 1'b1; alu_dest = 5'd5; alu_data = 32'hDEADBEEF;
    step();
    idle_inputs();
    chk_write("bypass_write", 1'b1, 5'd5, 32'hDEADBEEF);
    tests_run++;
    if (fifo_count !== 3'd0) begin
      tests_failed++;
      $display("FAIL bypass_count: got %0d, expected 0", fifo_count);
    end
    step();
    tests_run++;
    if (wren !== 1'b0 || wr !== 5'd5 || wd !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL bypass_hold: got wren=%b wr=%0d wd=%h, expected 0/5/deadbeef", wren, wr, wd);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_dest = 5'(20 + i); alu_data = 32'hA0 + 32'(i);
      step();
      chk_write("b2b_write", 1'b1, 5'(20 + i), 32'hA0 + 32'(i));
      tests_run++;
      if (fifo_count !== 3'd0) begin
        tests_failed++;
        $display("FAIL b2b_count: got %0d, expected 0", fifo_count);
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_load_priority();
    ld_valid = 1'b1; ld_dest = 5'd3; ld_data = 32'h11;
    alu_valid = 1'b1; alu_dest = 5'd7; alu_data = 32'h22;
    step();
    idle_inputs();
    chk_write("prio_load", 1'b1, 5'd3, 32'h11);
    tests_run++;
    if (fifo_count !== 3'd1) begin
      tests_failed++;
      $display("FAIL prio_count1: got %0d, expected 1", fifo_count);
    end
    step();
    chk_write("prio_alu", 1'b1, 5'd7, 32'h22);
    tests_run++;
    if (fifo_count !== 3'd0) begin
      tests_failed++;
      $display("FAIL prio_count0: got %0d, expected 0", fifo_count);
    end
    step();
    chk_write("prio_idle", 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_full();
    logic exp_ready [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      ld_valid = 1'b1; ld_dest = 5'(1 + i); ld_data = 32'h100 + 32'(i);
      alu_valid = 1'b1; alu_dest = 5'(8 + i); alu_data = 32'h200 + 32'(i);
      tests_run++;
      if (alu_ready !== exp_ready[i]) begin
        tests_failed++;
        $display("FAIL full_ready[%0d]: got %b, expected %b", i, alu_ready, exp_ready[i]);
      end
      step();
      chk_write("full_load", 1'b1, 5'(1 + i), 32'h100 + 32'(i));
    end
    idle_inputs();
    tests_run++;
    if (fifo_count !== 3'd4) begin
      tests_failed++;
      $display("FAIL full_count: got %0d, expected 4", fifo_count);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      chk_write("full_drain", 1'b1, 5'(8 + i), 32'h200 + 32'(i));
      tests_run++;
      if (fifo_count !== 3'(3 - i) || alu_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL full_drain_count[%0d]: got count=%0d ready=%b, expected %0d/1",
                 i, fifo_count, alu_ready, 3 - i);
      end
    end
    step();
    chk_write("full_done", 1'b0, 5'd0, 32'd0);
`ifdef REGFILE_WB_STALL_CNT_EN
    tests_run++;
    if (stall_cnt !== 32'd5) begin
      tests_failed++;
      $display("FAIL stall_cnt: got %0d, expected 5", stall_cnt);
    end
`endif
  endtask

  task automatic test_scoreboard();
    do_reset();
    iss_valid = 1'b1; iss_dest = 5'd9;
    step();
    idle_inputs();
    tests_run++;
    if (pending !== 32'h0000_0200) begin
      tests_failed++;
      $display("FAIL sb_set: got %h, expected 00000200", pending);
    end
    alu_valid = 1'b1; alu_dest = 5'd9; alu_data = 32'h99;
    step();
    idle_inputs();
    chk_write("sb_write", 1'b1, 5'd9, 32'h99);
    tests_run++;
    if (pending !== 32'd0) begin
      tests_failed++;
      $display("FAIL sb_clear: got %h, expected 00000000", pending);
    end
    iss_valid = 1'b1; iss_dest = 5'd9;
    step();
    alu_valid = 1'b1; alu_dest = 5'd9; alu_data = 32'h98;
    step();
    idle_inputs();
    chk_write("sb_write2", 1'b1, 5'd9, 32'h98);
    tests_run++;
    if (pending !== 32'h0000_0200) begin
      tests_failed++;
      $display("FAIL sb_set_wins: got %h, expected 00000200", pending);
    end
    alu_valid = 1'b1; alu_dest = 5'd9; alu_data = 32'h97;
    step();
    idle_inputs();
    tests_run++;
    if (pending !== 32'd0) begin
      tests_failed++;
      $display("FAIL sb_final_clear: got %h, expected 00000000", pending);
    end
  endtask

  task automatic test_zero_dest();
    step();
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_dest = 5'd0; alu_data = 32'h55;
      ld_valid = 1'b1; ld_dest = 5'd0; ld_data = 32'h66;
      iss_valid = 1'b1; iss_dest = 5'd0;
      step();
      tests_run++;
      if (wren !== 1'b0 || pending !== 32'd0 || fifo_count !== 3'd0) begin
        tests_failed++;
        $display("FAIL zero_dest[%0d]: got wren=%b pending=%h count=%0d, expected 0/0/0",
                 i, wren, pending, fifo_count);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_flush();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      iss_valid = 1'b1; iss_dest = 5'(8 + i);
      if (i > 0) begin
        ld_valid = 1'b1; ld_dest = 5'(i); ld_data = 32'(i);
        alu_valid = 1'b1; alu_dest = 5'(7 + i); alu_data = 32'h300 + 32'(i);
      end
      step();
    end
    idle_inputs();
    tests_run++;
    if (fifo_count !== 3'd3 || pending !== 32'h0000_0F00) begin
      tests_failed++;
      $display("FAIL flush_pre: got count=%0d pending=%h, expected 3/00000f00", fifo_count, pending);
    end
    do_reset();
    tests_run++;
    if (wren !== 1'b0 || wr !== 5'd0 || wd !== 32'd0 || pending !== 32'd0 ||
        fifo_count !== 3'd0 || alu_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_reset: got wren=%b wr=%0d wd=%h pending=%h count=%0d ready=%b",
               wren, wr, wd, pending, fifo_count, alu_ready);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      tests_run++;
      if (wren !== 1'b0 || fifo_count !== 3'd0) begin
        tests_failed++;
        $display("FAIL flush_after[%0d]: got wren=%b count=%0d, expected 0/0", i, wren, fifo_count);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #1;
    test_reset();
    test_bypass();
    test_back_to_back();
    test_load_priority();
    test_full();
    test_scoreboard();
    test_zero_dest();
    test_reset_flush();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
